ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 enable data reporting, 0xFF reset) from the FPGA to the mouse over the shared open-collector PS/2 clock/data pair. It is the outbound counterpart to the mouse receiver in the top level. It drives the lines only through active-low output enables, so the receiver keeps sampling the same pins. `busy` tells the receiver to discard traffic while a command is in flight.

---
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one byte (LSB first, odd parity, stop) to the device over the
// open-collector clock/data pair using active-low output enables only.
// Optional watchdog: define PS2_HOST_TX_TIMEOUT_EN to abort a transaction
// that has not finished within TIMEOUT_MS milliseconds.
//
// Handshake: send is a request strobe sampled only while idle (busy=0);
// the cycle it is seen high is the accept cycle, cmd is captured then,
// and busy stays high up to and including the single-cycle done pulse.
// Requests while busy are dropped. error is valid with done and held
// until the next accepted send.
module ps2_host_tx #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_MS = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       send,
   input  logic [7:0] cmd,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] state_dbg
);

   localparam int unsigned INHIBIT_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
   localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
   localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_START     = 3'd2,
      S_DATA      = 3'd3,
      S_ACK       = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             clk_s1_q, clk_s2_q, clk_prev_q;
   logic             dat_s1_q, dat_s2_q;
   logic [9:0]       sh_q, sh_d;
   logic [3:0]       idx_q, idx_d;
   logic [INH_W-1:0] inh_q, inh_d;
   logic             dat_oe_q, dat_oe_d;
   logic             err_q, err_d;
   logic             fall, inh_done, lines_idle, tmo;

   assign fall       = clk_prev_q & ~clk_s2_q;
   assign inh_done   = (inh_q == INH_LAST);
   assign lines_idle = clk_s2_q & dat_s2_q;

`ifdef PS2_HOST_TX_TIMEOUT_EN
   localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYC);
   logic [19:0] wd_q;

   // Watchdog: cleared on accept, counts every non-idle cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_q <= '0;
      end else if (state_q == S_IDLE) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_q + 20'd1;
      end
   end

   assign tmo = (state_q != S_IDLE) && (wd_q == WD_LAST);
`else
   assign tmo = 1'b0;
`endif

   // Two-stage synchronizers plus a registered copy of the clock for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_in;
         dat_s2_q   <= dat_s1_q;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the watchdog overrides every state.
   always_comb begin
      state_d = state_q;
      if (tmo) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      if (send) state_d = S_INHIBIT;
            S_INHIBIT:   if (inh_done) state_d = S_START;
            S_START:     state_d = S_DATA;
            S_DATA:      if (fall && (idx_q == 4'd9)) state_d = S_ACK;
            S_ACK:       if (fall) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (lines_idle) state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Datapath next values: frame shift register, bit index, inhibit timer, data enable, error.
   always_comb begin
      sh_d     = sh_q;
      idx_d    = idx_q;
      inh_d    = inh_q;
      dat_oe_d = dat_oe_q;
      err_d    = err_q;
      if (tmo) begin
         dat_oe_d = 1'b0;
         err_d    = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               dat_oe_d = 1'b0;
               if (send) begin
                  // Frame after the start bit: data LSB first, odd parity, stop.
                  sh_d  = {1'b1, ~^cmd, cmd};
                  idx_d = '0;
                  inh_d = '0;
                  err_d = 1'b0;
               end
            end
            S_INHIBIT: begin
               inh_d = inh_q + 1'b1;
               if (inh_done) dat_oe_d = 1'b1;  // start bit goes out with START
            end
            S_START: idx_d = '0;
            S_DATA: begin
               if (fall) begin
                  dat_oe_d = ~sh_q[0];
                  sh_d     = {1'b1, sh_q[9:1]};
                  idx_d    = idx_q + 4'd1;
               end
            end
            S_ACK: if (fall && dat_s2_q) err_d = 1'b1;
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q     <= '0;
         idx_q    <= '0;
         inh_q    <= '0;
         dat_oe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         idx_q    <= idx_d;
         inh_q    <= inh_d;
         dat_oe_q <= dat_oe_d;
         err_q    <= err_d;
      end
   end

   // Outputs; a watchdog hit releases both lines in the done cycle itself.
   always_comb begin
      ps2_clk_oe = (state_q == S_INHIBIT) && !tmo;
      ps2_dat_oe = dat_oe_q && !tmo;
      busy       = (state_q != S_IDLE);
      done       = ((state_q == S_WAIT_IDLE) && lines_idle) || tmo;
      error      = err_q || tmo;
      state_dbg  = state_q;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized frames against a PS/2 device model.
module tb_ps2_host_tx;
   localparam int unsigned CLK_FREQ   = 1_000_000;
   localparam int unsigned INHIBIT_US = 100;
   localparam int unsigned TIMEOUT_MS = 15;
   localparam int INH  = CLK_FREQ / 1_000_000 * INHIBIT_US;
   localparam int TMO  = CLK_FREQ / 1000 * TIMEOUT_MS;
   localparam int HALF = 40;  // 12.5 kHz device clock at 1 MHz system clock

   logic       clk = 1'b0;
   logic       reset_n;
   logic       send;
   logic [7:0] cmd;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;
   logic [2:0] state_dbg;
   logic       dev_clk_low, dev_dat_low;

   int         checks = 0;
   int         errors = 0;
   int         done_cnt = 0;
   logic       done_err = 1'b0, done_busy = 1'b0, busy_after = 1'b1, prev_done = 1'b0;
   logic [9:0] exp_q[$];

   // Open-collector wired-AND of host and device on each line.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .INHIBIT_US(INHIBIT_US),
      .TIMEOUT_MS(TIMEOUT_MS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .send      (send),
      .cmd       (cmd),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // Record every done pulse with the error/busy seen alongside it and busy one cycle later.
   always @(negedge clk) begin
      if (prev_done) busy_after = busy;
      if (done) begin
         done_cnt++;
         done_err  = error;
         done_busy = busy;
      end
      prev_done = done;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bits the device should see after the start bit: data LSB first, odd parity, stop.
   function automatic logic [9:0] frame_of(input logic [7:0] c);
      logic par;
      par = ($countones(c) % 2 == 0);
      return {1'b1, par, c};
   endfunction

   task automatic run_frame(input logic [7:0] c, input bit ack, input bit glitch, input int rst_after);
      int         cnt, d0;
      logic [9:0] seen, exp;
      bit         aborted;
      exp_q.push_back(frame_of(c));
      d0      = done_cnt;
      seen    = '0;
      aborted = 1'b0;
      @(negedge clk);
      cmd  = c;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      cmd  = 8'($urandom);
      check("busy_on_accept", busy, 1);
      check("clk_oe_on_accept", ps2_clk_oe, 1);
      check("error_cleared", error, 0);
      cnt = 0;
      while (ps2_clk_oe && cnt < INH + 5) begin
         cnt++;
         @(negedge clk);
      end
      check("inhibit_len", cnt, INH);
      check("start_dat_oe", ps2_dat_oe, 1);
      check("start_clk_released", ps2_clk_in, 1);
      repeat (20) @(negedge clk);
      for (int f = 1; f <= 11 && !aborted; f++) begin
         if (f == 11) dev_dat_low = ack;
         dev_clk_low = 1'b1;
         for (int i = 0; i < HALF; i++) begin
            if (glitch && f == 3 && i == 10) begin
               send = 1'b1;
               cmd  = 8'hAA;
            end
            if (glitch && f == 3 && i == 11) send = 1'b0;
            @(negedge clk);
         end
         if (f <= 10) seen[f-1] = ps2_dat_in;
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clk);
         if (rst_after != 0 && f == rst_after) begin
            #2 reset_n = 1'b0;
            #1;
            check("rst_clk_oe", ps2_clk_oe, 0);
            check("rst_dat_oe", ps2_dat_oe, 0);
            check("rst_busy", busy, 0);
            aborted = 1'b1;
         end
      end
      dev_dat_low = 1'b0;
      if (aborted) begin
         void'(exp_q.pop_front());
         repeat (5) @(negedge clk);
         reset_n = 1'b1;
         repeat (5) @(negedge clk);
         check("rst_no_done", done_cnt - d0, 0);
      end else begin
         repeat (20) @(negedge clk);
         exp = exp_q.pop_front();
         check("frame_bits", seen, exp);
         check("done_count", done_cnt - d0, 1);
         check("done_error", done_err, !ack);
         check("busy_with_done", done_busy, 1);
         check("busy_after_done", busy_after, 0);
         check("error_held", error, !ack);
      end
   endtask

   initial begin
      int cnt, d0;
      reset_n     = 1'b0;
      send        = 1'b0;
      cmd         = 8'h00;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_clk_oe", ps2_clk_oe, 0);
      check("reset_dat_oe", ps2_dat_oe, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      run_frame(8'hF4, 1'b1, 1'b0, 0);
      run_frame(8'h00, 1'b1, 1'b0, 0);
      run_frame(8'hFF, 1'b1, 1'b0, 0);

      // No ack: error must survive idle time until the next accepted send.
      run_frame(8'h5A, 1'b0, 1'b0, 0);
      repeat (50) @(negedge clk);
      check("nack_error_still_held", error, 1);

      // A request during DATA is dropped.
      run_frame(8'h96, 1'b1, 1'b1, 0);

      // Reset after the 4th data bit, then a normal 0xFF.
      run_frame(8'h37, 1'b1, 1'b0, 4);
      run_frame(8'hFF, 1'b1, 1'b0, 0);

      for (int n = 0; n < 4; n++) begin
         run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 0);
      end

      // Device that never clocks.
      d0 = done_cnt;
      @(negedge clk);
      cmd  = 8'hF4;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      cnt = 0;
      while (!done && cnt < TMO + 50) begin
         cnt++;
         @(negedge clk);
      end
      check("timeout_cycles", cnt, TMO);
      check("timeout_error", error, 1);
      check("timeout_clk_released", ps2_clk_oe, 0);
      check("timeout_dat_released", ps2_dat_oe, 0);
      check("timeout_busy_with_done", busy, 1);
      @(negedge clk);
      check("timeout_busy_after", busy, 0);
      check("timeout_done_count", done_cnt - d0, 1);
`else
      repeat (3000) @(negedge clk);
      check("silent_device_busy", busy, 1);
      check("silent_device_no_done", done_cnt - d0, 0);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("silent_device_reset_busy", busy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
